// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the video test-pattern generator: mode encodings
// and the colour-bar order.
package test_pattern_gen_pkg;

  localparam logic [2:0] MODE_GRID    = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_RAMP    = 3'd3;
  localparam logic [2:0] MODE_SOLID   = 3'd4;

  // {r,g,b} on/off per bar index: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [2:0] BAR_RGB [0:7] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/test_pattern_gen_bar_tracker.sv
// Tracks which of the eight colour bars the current pixel falls in, assuming
// i_hpos advances by one per clock within a line and restarts at zero.
module test_pattern_gen_bar_tracker #(
  parameter int H_BITS = 10,
  parameter int BAR_W  = 80
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [H_BITS-1:0] i_hpos,
  output logic [2:0]        o_bar
);

  localparam int COL_BITS = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [COL_BITS-1:0] col_q;
  logic [2:0]          bar_q;
  logic                line_start;

  assign line_start = (i_hpos == '0);
  assign o_bar      = line_start ? 3'd0 : bar_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      bar_q <= 3'd0;
    end else if (line_start) begin
      // Pixel 0 already occupies bar 0, so counting resumes from column 1.
      if (BAR_W == 1) begin
        col_q <= '0;
        bar_q <= 3'd1;
      end else begin
        col_q <= COL_BITS'(1);
        bar_q <= 3'd0;
      end
    end else if (col_q == COL_BITS'(BAR_W - 1)) begin
      col_q <= '0;
      if (bar_q != 3'd7) bar_q <= bar_q + 3'd1;
    end else begin
      col_q <= col_q + COL_BITS'(1);
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode video test-pattern generator with frame-synchronous mode
// switching and a one-clock registered colour output.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 10,
  parameter int COLOR_BITS = 8,
  parameter int H_ACTIVE   = 640,
  parameter int GRID_SHIFT = 3,
  parameter int TILE_SHIFT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [H_BITS-1:0]     i_hpos,
  input  logic [V_BITS-1:0]     i_vpos,
  input  logic                  i_visible,
  input  logic                  i_frame_start,
  input  logic [2:0]            i_mode,
  output logic [COLOR_BITS-1:0] o_r,
  output logic [COLOR_BITS-1:0] o_g,
  output logic [COLOR_BITS-1:0] o_b,
  output logic                  o_visible,
  output logic [2:0]            o_mode
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]            mode_q;
  logic [7:0]            frame_q;
  logic [2:0]            bar;
  logic [H_BITS-1:0]     checker_sum;
  logic [COLOR_BITS-1:0] ramp;
  logic                  r_on, g_on, b_on, use_ramp;
  logic [COLOR_BITS-1:0] r_px, g_px, b_px;
  logic                  unused_bits;

  test_pattern_gen_bar_tracker #(
    .H_BITS (H_BITS),
    .BAR_W  (BAR_W)
  ) bar_tracker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hpos  (i_hpos),
    .o_bar   (bar)
  );

  // The pixel sampled with i_frame_start still sees the old mode and frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q  <= MODE_GRID;
      frame_q <= 8'd0;
    end else if (i_frame_start) begin
      mode_q  <= i_mode;
      frame_q <= frame_q + 8'd1;
    end
  end

  assign checker_sum = i_hpos + H_BITS'(frame_q);
  assign ramp        = i_hpos[H_BITS-1 -: COLOR_BITS];
  // Only a few row bits and one sum bit select the pattern; the rest are don't-care.
  assign unused_bits = ^{i_vpos, checker_sum};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    r_on     = 1'b0;
    g_on     = 1'b0;
    b_on     = 1'b0;
    use_ramp = 1'b0;
    case (mode_q)
      MODE_GRID: begin
        r_on = (i_hpos[GRID_SHIFT-1:0] == '0) || (i_vpos[GRID_SHIFT-1:0] == '0);
        g_on = i_vpos[TILE_SHIFT];
        b_on = i_hpos[TILE_SHIFT];
      end
      MODE_BARS:    {r_on, g_on, b_on} = BAR_RGB[bar];
      MODE_CHECKER: begin
        r_on = checker_sum[TILE_SHIFT] ^ i_vpos[TILE_SHIFT];
        g_on = r_on;
        b_on = r_on;
      end
      MODE_RAMP:    use_ramp = 1'b1;
      MODE_SOLID:   {r_on, g_on, b_on} = 3'b111;
      default:      ;
    endcase
  end

  assign r_px = !i_visible ? '0 : (use_ramp ? ramp : {COLOR_BITS{r_on}});
  assign g_px = !i_visible ? '0 : (use_ramp ? ramp : {COLOR_BITS{g_on}});
  assign b_px = !i_visible ? '0 : (use_ramp ? ramp : {COLOR_BITS{b_on}});

  // NOTE: all flops here are plain registers with an async reset; the design
  // holds no memory arrays that would need a separate clear scheme.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r       <= '0;
      o_g       <= '0;
      o_b       <= '0;
      o_visible <= 1'b0;
    end else begin
      o_r       <= r_px;
      o_g       <= g_px;
      o_b       <= b_px;
      o_visible <= i_visible;
    end
  end

  assign o_mode = mode_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed self-checking bench for test_pattern_gen with default parameters.
module tb_test_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       visible;
  logic       frame_start;
  logic [2:0] mode;
  logic [7:0] r, g, b;
  logic       vis_out;
  logic [2:0] mode_out;

  int assertions = 0;
  int failures   = 0;

  test_pattern_gen dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_hpos        (hpos),
    .i_vpos        (vpos),
    .i_visible     (visible),
    .i_frame_start (frame_start),
    .i_mode        (mode),
    .o_r           (r),
    .o_g           (g),
    .o_b           (b),
    .o_visible     (vis_out),
    .o_mode        (mode_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one pixel, clock it, and settle 1 time unit past the edge.
  task automatic step(input int h, input int v, input logic vis, input logic fs,
                      input logic [2:0] m);
    hpos        = 10'(h);
    vpos        = 10'(v);
    visible     = vis;
    frame_start = fs;
    mode        = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hpos = 10'd17; vpos = 10'd17; visible = 1'b1;
    frame_start = 1'b0; mode = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    if ({r, g, b} !== 24'h000000) begin
      failures++; $display("FAIL reset_rgb: got %h expected %h", {r, g, b}, 24'h000000);
    end
    assertions++;
    if (vis_out !== 1'b0 || mode_out !== 3'd0) begin
      failures++; $display("FAIL reset_vis_mode: got %b/%0d expected 0/0", vis_out, mode_out);
    end
    assertions++;
    rst_n = 1'b1;
    step(17, 17, 1'b1, 1'b0, 3'd4);
    if ({r, g, b} !== 24'h00FFFF) begin
      failures++; $display("FAIL reset_release_grid: got %h expected %h", {r, g, b}, 24'h00FFFF);
    end
    assertions++;
    if (mode_out !== 3'd0 || vis_out !== 1'b1) begin
      failures++; $display("FAIL reset_release_mode: got %0d/%b expected 0/1", mode_out, vis_out);
    end
    assertions++;
  endtask

  task automatic test_grid();
    step(8, 3, 1'b1, 1'b0, 3'd0);
    if ({r, g, b} !== 24'hFF0000) begin
      failures++; $display("FAIL grid_8_3: got %h expected %h", {r, g, b}, 24'hFF0000);
    end
    assertions++;
    step(9, 9, 1'b1, 1'b0, 3'd0);
    if ({r, g, b} !== 24'h000000) begin
      failures++; $display("FAIL grid_9_9: got %h expected %h", {r, g, b}, 24'h000000);
    end
    assertions++;
    step(16, 16, 1'b1, 1'b0, 3'd0);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL grid_16_16: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
  endtask

  task automatic test_bars();
    step(700, 0, 1'b0, 1'b1, 3'd1);
    for (int h = 0; h < 640; h++) begin
      step(h, 1, 1'b1, 1'b0, 3'd1);
      if (h < 80) begin
        if ({r, g, b} !== 24'hFFFFFF) begin
          failures++; $display("FAIL bars_white h=%0d: got %h expected %h", h, {r, g, b}, 24'hFFFFFF);
        end
        assertions++;
      end
      if (h == 80) begin
        if ({r, g, b} !== 24'hFFFF00) begin
          failures++; $display("FAIL bars_yellow: got %h expected %h", {r, g, b}, 24'hFFFF00);
        end
        assertions++;
      end
      if (h == 320) begin
        if ({r, g, b} !== 24'hFF00FF) begin
          failures++; $display("FAIL bars_magenta: got %h expected %h", {r, g, b}, 24'hFF00FF);
        end
        assertions++;
      end
      if (h == 639) begin
        if ({r, g, b} !== 24'h000000) begin
          failures++; $display("FAIL bars_black: got %h expected %h", {r, g, b}, 24'h000000);
        end
        assertions++;
      end
    end
    for (int h = 640; h < 660; h++) step(h, 1, 1'b0, 1'b0, 3'd1);
    step(0, 2, 1'b1, 1'b0, 3'd1);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL bars_restart: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
  endtask

  task automatic test_mode_latch();
    for (int h = 0; h <= 200; h++) step(h, 3, 1'b1, 1'b0, (h >= 100) ? 3'd3 : 3'd1);
    if ({r, g, b} !== 24'h00FFFF || mode_out !== 3'd1) begin
      failures++; $display("FAIL latch_no_fs: got %h/%0d expected %h/1", {r, g, b}, mode_out, 24'h00FFFF);
    end
    assertions++;
    step(201, 3, 1'b1, 1'b1, 3'd3);
    if ({r, g, b} !== 24'h00FFFF) begin
      failures++; $display("FAIL latch_fs_pixel_old_mode: got %h expected %h", {r, g, b}, 24'h00FFFF);
    end
    assertions++;
    if (mode_out !== 3'd3) begin
      failures++; $display("FAIL latch_o_mode: got %0d expected 3", mode_out);
    end
    assertions++;
    step(400, 3, 1'b1, 1'b0, 3'd3);
    if ({r, g, b} !== 24'h646464) begin
      failures++; $display("FAIL ramp_400: got %h expected %h", {r, g, b}, 24'h646464);
    end
    assertions++;
  endtask

  task automatic test_checker();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(700, 0, 1'b0, 1'b1, 3'd2);      // frame_q 0 -> 1
    step(0, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'h000000) begin
      failures++; $display("FAIL checker_f1_0_0: got %h expected %h", {r, g, b}, 24'h000000);
    end
    assertions++;
    step(16, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL checker_f1_16_0: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
    step(15, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL checker_f1_15_0: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
    step(0, 16, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL checker_f1_0_16: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
    repeat (15) step(700, 0, 1'b0, 1'b1, 3'd2);   // frame_q = 16
    step(0, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL checker_f16_0_0: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
    repeat (240) step(700, 0, 1'b0, 1'b1, 3'd2);  // frame_q wraps to 0
    step(0, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'h000000) begin
      failures++; $display("FAIL checker_wrap_0_0: got %h expected %h", {r, g, b}, 24'h000000);
    end
    assertions++;
    step(15, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'h000000) begin
      failures++; $display("FAIL checker_wrap_15_0: got %h expected %h", {r, g, b}, 24'h000000);
    end
    assertions++;
    step(16, 0, 1'b1, 1'b0, 3'd2);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL checker_wrap_16_0: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
  endtask

  task automatic test_blanking();
    step(700, 0, 1'b0, 1'b1, 3'd4);
    step(10, 10, 1'b1, 1'b0, 3'd4);
    if ({r, g, b} !== 24'hFFFFFF || vis_out !== 1'b1) begin
      failures++; $display("FAIL solid_visible: got %h/%b expected %h/1", {r, g, b}, vis_out, 24'hFFFFFF);
    end
    assertions++;
    step(10, 10, 1'b0, 1'b0, 3'd4);
    if ({r, g, b} !== 24'h000000 || vis_out !== 1'b0) begin
      failures++; $display("FAIL solid_blanked: got %h/%b expected %h/0", {r, g, b}, vis_out, 24'h000000);
    end
    assertions++;
    step(700, 0, 1'b0, 1'b1, 3'd5);
    step(10, 10, 1'b1, 1'b0, 3'd5);
    if ({r, g, b} !== 24'h000000 || mode_out !== 3'd5) begin
      failures++; $display("FAIL reserved_black: got %h/%0d expected %h/5", {r, g, b}, mode_out, 24'h000000);
    end
    assertions++;
  endtask

  task automatic test_async_reset();
    step(5, 5, 1'b1, 1'b1, 3'd4);
    step(6, 5, 1'b1, 1'b0, 3'd4);
    if ({r, g, b} !== 24'hFFFFFF) begin
      failures++; $display("FAIL async_pre_white: got %h expected %h", {r, g, b}, 24'hFFFFFF);
    end
    assertions++;
    #2 rst_n = 1'b0;
    #1;
    if ({r, g, b} !== 24'h000000 || vis_out !== 1'b0 || mode_out !== 3'd0) begin
      failures++; $display("FAIL async_reset: got %h/%b/%0d expected 000000/0/0", {r, g, b}, vis_out, mode_out);
    end
    assertions++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(17, 17, 1'b1, 1'b0, 3'd4);
    if ({r, g, b} !== 24'h00FFFF) begin
      failures++; $display("FAIL async_release_grid: got %h expected %h", {r, g, b}, 24'h00FFFF);
    end
    assertions++;
  endtask

  initial begin
    test_reset();
    test_grid();
    test_bars();
    test_mode_latch();
    test_checker();
    test_blanking();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
